ijtc_update_scheduler: RTL

IJTC_UPDATE_SCHEDULER -- requirements
Module: ijtc_update_scheduler

---
 rtl/ijtc_update_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ijtc_update_scheduler.sv
// Update scheduler for an indirect-jump target cache (IJTC): clears the table after reset,
// queues taken front-end updates, applies back-end repairs, and keeps the speculative GHR.
module ijtc_update_scheduler #(
    parameter int IDX_W  = 8,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_valid_i,
    output logic             dir_ready_o,
    input  logic [31:0]      dir_pc_i,
    input  logic             dir_take_i,
    input  logic [31:0]      dir_dest_i,
    input  logic             rep_valid_i,
    input  logic [IDX_W-1:0] rep_checkpoint_i,
    input  logic [31:0]      rep_pc_i,
    input  logic             rep_take_i,
    input  logic [31:0]      rep_dest_i,
    output logic [IDX_W-1:0] ghr_o,
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_index_o,
    output logic [7:0]       wr_tag_o,
    output logic [31:0]      wr_data_o,
    output logic             wr_valid_o,
    output logic             init_busy_o
);

    localparam int PTR_W = $clog2(QDEPTH);

    typedef enum logic [1:0] {INIT, RUN, REPAIR} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] r_ghr;
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [IDX_W-1:0] r_rep_index;
    logic [7:0]       r_rep_tag;
    logic [31:0]      r_rep_dest;
    logic             r_rep_take;

    logic [IDX_W-1:0] r_q_index [QDEPTH];
    logic [7:0]       r_q_tag   [QDEPTH];
    logic [31:0]      r_q_data  [QDEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_run;
    logic             w_accept;
    logic             w_enq;
    logic             w_deq;
    logic             w_repair_req;
    logic [IDX_W-1:0] w_dir_index;
    logic [7:0]       w_dir_tag;
    logic [IDX_W-1:0] w_rep_index;
    logic [7:0]       w_rep_tag;
    logic [PTR_W-1:0] w_head;
    logic             w_unused_bits;

    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_run   = (r_state == RUN);
    assign w_head  = r_rd_ptr[PTR_W-1:0];

    // A repair in the same cycle blocks both acceptance and draining, so nothing
    // queued before the repair can reach the table.
    assign dir_ready_o  = w_run & ~w_full & ~rep_valid_i;
    assign w_accept     = dir_valid_i & dir_ready_o;
    assign w_enq        = w_accept & dir_take_i;
    assign w_deq        = w_run & ~w_empty & ~rep_valid_i;
    assign w_repair_req = rep_valid_i & (r_state != INIT);

    assign w_dir_index = dir_pc_i[IDX_W+1:2] ^ r_ghr;
    assign w_dir_tag   = dir_pc_i[IDX_W+9:IDX_W+2];
    assign w_rep_index = rep_pc_i[IDX_W+1:2] ^ rep_checkpoint_i;
    assign w_rep_tag   = rep_pc_i[IDX_W+9:IDX_W+2];

    assign w_unused_bits = ^{dir_pc_i[1:0], rep_pc_i[1:0], dir_pc_i[31:IDX_W+10], rep_pc_i[31:IDX_W+10]};

    assign ghr_o       = r_ghr;
    assign init_busy_o = (r_state == INIT);

    always_comb begin
        wr_en_o    = 1'b0;
        wr_index_o = '0;
        wr_tag_o   = '0;
        wr_data_o  = '0;
        wr_valid_o = 1'b0;
        case (r_state)
            INIT: begin
                wr_en_o    = 1'b1;
                wr_index_o = r_sweep;
            end
            REPAIR: begin
                wr_en_o    = 1'b1;
                wr_index_o = r_rep_index;
                wr_tag_o   = r_rep_tag;
                wr_data_o  = r_rep_dest;
                wr_valid_o = r_rep_take;
            end
            RUN: begin
                if (w_deq) begin
                    wr_en_o    = 1'b1;
                    wr_index_o = r_q_index[w_head];
                    wr_tag_o   = r_q_tag[w_head];
                    wr_data_o  = r_q_data[w_head];
                    wr_valid_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_ghr       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rep_index <= '0;
            r_rep_tag   <= '0;
            r_rep_dest  <= '0;
            r_rep_take  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_sweep <= r_sweep + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (r_sweep == {IDX_W{1'b1}}) begin
                        r_state <= RUN;
                    end
                end
                RUN, REPAIR: begin
                    if (w_repair_req) begin
                        // Newest repair wins; the previously latched one is still written this cycle.
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_ghr       <= {rep_checkpoint_i[IDX_W-2:0], rep_take_i};
                        r_rep_index <= w_rep_index;
                        r_rep_tag   <= w_rep_tag;
                        r_rep_dest  <= rep_dest_i;
                        r_rep_take  <= rep_take_i;
                        r_state     <= REPAIR;
                    end else if (r_state == REPAIR) begin
                        r_state <= RUN;
                    end else begin
                        if (w_accept) begin
                            r_ghr <= {r_ghr[IDX_W-2:0], dir_take_i};
                        end
                        if (w_enq) begin
                            r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
                        end
                        if (w_deq) begin
                            r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
                        end
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    // Queue storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_index[r_wr_ptr[PTR_W-1:0]] <= w_dir_index;
            r_q_tag[r_wr_ptr[PTR_W-1:0]]   <= w_dir_tag;
            r_q_data[r_wr_ptr[PTR_W-1:0]]  <= dir_dest_i;
        end
    end

endmodule
